// File: rtl/nmi_sram_responder.sv
// Native-memory-interface responder backed by a word-addressed RAM with
// byte-strobe writes, programmable wait states, out-of-range detection
// and read/write transfer counters.
module nmi_sram_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WSTRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [DATA_WIDTH-1:0] OOB_RDATA = DATA_WIDTH'(32'hDEADBEEF)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_mem_valid,
  output logic                   s_mem_ready,
  input  logic                   s_mem_instr,
  input  logic [ADDR_WIDTH-1:0]  s_mem_addr,
  input  logic [DATA_WIDTH-1:0]  s_mem_wdata,
  input  logic [WSTRB_WIDTH-1:0] s_mem_wstrb,
  output logic [DATA_WIDTH-1:0]  s_mem_rdata,
  output logic                   oob_err,
  output logic [15:0]            rd_cnt,
  output logic [15:0]            wr_cnt
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned WCNT_W = 4;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
  logic                   latch_c;
  logic                   enter_resp_c;

  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [WSTRB_WIDTH-1:0] wstrb_q;
  logic                   instr_q;

  logic [ADDR_WIDTH-1:0]  req_addr_c;
  logic [DATA_WIDTH-1:0]  req_wdata_c;
  logic [WSTRB_WIDTH-1:0] req_wstrb_c;
  logic                   req_instr_c;
  logic [ADDR_WIDTH-1:0]  off_c;
  logic [IDX_W-1:0]       idx_c;
  logic                   oob_c;
  logic                   is_read_c;
  logic                   count_rd_c;

  logic [DATA_WIDTH-1:0]  mem [DEPTH_WORDS];

  // State register and wait counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state logic: request acceptance, wait countdown, abort and response
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    latch_c      = 1'b0;
    enter_resp_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s_mem_valid) begin
          latch_c = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d      = ST_RESP;
            enter_resp_c = 1'b1;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = WCNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!s_mem_valid) begin
          // master withdrew the request: drop it silently
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == '0) begin
          state_d      = ST_RESP;
          enter_resp_c = 1'b1;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request capture in IDLE; later bus changes are ignored
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      instr_q <= 1'b0;
    end else if (latch_c) begin
      addr_q  <= s_mem_addr;
      wdata_q <= s_mem_wdata;
      wstrb_q <= s_mem_wstrb;
      instr_q <= s_mem_instr;
    end
  end

  // Effective request: live bus on a zero-wait accept, latched copy otherwise
  always_comb begin
    req_addr_c  = addr_q;
    req_wdata_c = wdata_q;
    req_wstrb_c = wstrb_q;
    req_instr_c = instr_q;
    if (state_q == ST_IDLE) begin
      req_addr_c  = s_mem_addr;
      req_wdata_c = s_mem_wdata;
      req_wstrb_c = s_mem_wstrb;
      req_instr_c = s_mem_instr;
    end
    off_c      = req_addr_c - BASE_ADDR;
    idx_c      = off_c[IDX_W+1:2];
    oob_c      = (req_addr_c < BASE_ADDR) ||
                 ((off_c >> 2) >= ADDR_WIDTH'(DEPTH_WORDS));
    is_read_c  = (req_wstrb_c == '0);
    count_rd_c = is_read_c || req_instr_c;
  end

  // Response data, ready pulse, sticky error and transfer counters
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s_mem_ready <= 1'b0;
      s_mem_rdata <= '0;
      oob_err     <= 1'b0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
    end else begin
      s_mem_ready <= enter_resp_c;
      if (enter_resp_c) begin
        if (!is_read_c) begin
          s_mem_rdata <= '0;
        end else if (oob_c) begin
          s_mem_rdata <= OOB_RDATA;
        end else begin
          s_mem_rdata <= mem[idx_c];
        end
        if (oob_c) begin
          oob_err <= 1'b1;
        end
        if (count_rd_c) begin
          rd_cnt <= rd_cnt + CNT_W'(1);
        end else begin
          wr_cnt <= wr_cnt + CNT_W'(1);
        end
      end
    end
  end

  // RAM byte-strobe write on the edge entering RESP; contents never reset
  always_ff @(posedge clk) begin
    if (rstn && enter_resp_c && !oob_c && !is_read_c) begin
      for (int k = 0; k < WSTRB_WIDTH; k++) begin
        if (req_wstrb_c[k]) begin
          mem[idx_c][8*k +: 8] <= req_wdata_c[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_nmi_sram_responder.sv
// Directed bench: three responders (0, 1 and 3 wait states) on a shared
// clock and reset, checked against hand-computed values.
module tb_nmi_sram_responder;

  localparam int unsigned N = 3;

  logic        clk;
  logic        rstn;
  logic        valid [N];
  logic        ready [N];
  logic        instr [N];
  logic [31:0] addr  [N];
  logic [31:0] wdata [N];
  logic [3:0]  wstrb [N];
  logic [31:0] rdata [N];
  logic        oob   [N];
  logic [15:0] rdc   [N];
  logic [15:0] wrc   [N];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: 0 wait states, 1: 1 wait state, 2: 3 wait states
  for (genvar g = 0; g < N; g++) begin : g_dut
    nmi_sram_responder #(
      .WAIT_CYCLES((g == 2) ? 3 : g)
    ) u_dut (
      .clk         (clk),
      .rstn        (rstn),
      .s_mem_valid (valid[g]),
      .s_mem_ready (ready[g]),
      .s_mem_instr (instr[g]),
      .s_mem_addr  (addr[g]),
      .s_mem_wdata (wdata[g]),
      .s_mem_wstrb (wstrb[g]),
      .s_mem_rdata (rdata[g]),
      .oob_err     (oob[g]),
      .rd_cnt      (rdc[g]),
      .wr_cnt      (wrc[g])
    );
  end

  function automatic int wait_of(input int i);
    return (i == 2) ? 3 : i;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transfer: checks latency and returned data, ends in IDLE
  task automatic xfer(input int i, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp_rd, input string tag);
    int  cyc;
    logic got;
    @(negedge clk);
    valid[i] = 1'b1;
    addr[i]  = a;
    wdata[i] = d;
    wstrb[i] = s;
    cyc = 0;
    got = 1'b0;
    while (cyc < 20 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      got = ready[i];
    end
    valid[i] = 1'b0;
    check({tag, "_lat"}, 32'(cyc), 32'(wait_of(i) + 1));
    check({tag, "_rdata"}, rdata[i], exp_rd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic seen;
    rstn = 1'b0;
    for (int i = 0; i < N; i++) begin
      valid[i] = 1'b0;
      instr[i] = 1'b0;
      addr[i]  = '0;
      wdata[i] = '0;
      wstrb[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready[1]), 32'd0);
    check("rst_rdata", rdata[1], 32'd0);
    check("rst_oob", 32'(oob[1]), 32'd0);
    check("rst_rdcnt", 32'(rdc[1]), 32'd0);
    check("rst_wrcnt", 32'(wrc[1]), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // 1 wait state: write then read back
    xfer(1, 32'h10, 32'h12345678, 4'hF, 32'h0, "t1_wr");
    xfer(1, 32'h10, 32'h0, 4'h0, 32'h12345678, "t1_rd");
    check("t1_wrcnt", 32'(wrc[1]), 32'd1);
    check("t1_rdcnt", 32'(rdc[1]), 32'd1);

    // Byte strobes
    xfer(1, 32'h20, 32'hAABBCCDD, 4'hF, 32'h0, "t2_init");
    xfer(1, 32'h20, 32'h11223344, 4'b0101, 32'h0, "t2_strb");
    xfer(1, 32'h20, 32'h0, 4'h0, 32'hAA22CC44, "t2_rd");

    // Out of range: first word past the end, aliasing index 0
    xfer(1, 32'h0, 32'h55AA55AA, 4'hF, 32'h0, "t3_w0");
    check("t3_oob_pre", 32'(oob[1]), 32'd0);
    xfer(1, 32'h400, 32'h0, 4'h0, 32'hDEADBEEF, "t3_oobrd");
    check("t3_oob", 32'(oob[1]), 32'd1);
    xfer(1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, "t3_oobwr");
    xfer(1, 32'h0, 32'h0, 4'h0, 32'h55AA55AA, "t3_alias");
    check("t3_rdcnt", 32'(rdc[1]), 32'd4);
    check("t3_wrcnt", 32'(wrc[1]), 32'd5);

    // Abort during WAIT with 3 wait states
    xfer(2, 32'h40, 32'h11111111, 4'hF, 32'h0, "t4_wr");
    @(negedge clk);
    valid[2] = 1'b1;
    addr[2]  = 32'h40;
    wdata[2] = 32'h22222222;
    wstrb[2] = 4'hF;
    @(posedge clk);
    #1;
    @(negedge clk);
    valid[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen = seen | ready[2];
    end
    check("t4_noready", 32'(seen), 32'd0);
    check("t4_wrcnt", 32'(wrc[2]), 32'd1);
    check("t4_rdcnt", 32'(rdc[2]), 32'd0);
    xfer(2, 32'h40, 32'h0, 4'h0, 32'h11111111, "t4_rd");
    check("t4_rdcnt2", 32'(rdc[2]), 32'd1);

    // Zero wait states, valid held over four reads (instruction fetches)
    xfer(0, 32'h10, 32'h0F0F0F0F, 4'hF, 32'h0, "t5_wr");
    @(negedge clk);
    valid[0] = 1'b1;
    instr[0] = 1'b1;
    addr[0]  = 32'h10;
    wstrb[0] = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t5_ready_c%0d", k), 32'(ready[0]), 32'(k % 2));
      if (k % 2 == 1) begin
        check($sformatf("t5_rdata_c%0d", k), rdata[0], 32'h0F0F0F0F);
      end
      if (k == 7) begin
        valid[0] = 1'b0;
        instr[0] = 1'b0;
      end
    end
    check("t5_rdcnt", 32'(rdc[0]), 32'd4);
    check("t5_wrcnt", 32'(wrc[0]), 32'd1);

    // Reset during WAIT: dropped write, cleared state, RAM retained
    @(negedge clk);
    valid[2] = 1'b1;
    addr[2]  = 32'h40;
    wdata[2] = 32'h0BADF00D;
    wstrb[2] = 4'hF;
    @(posedge clk);
    #1;
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("t6_ready", 32'(ready[2]), 32'd0);
    check("t6_rdcnt", 32'(rdc[2]), 32'd0);
    check("t6_wrcnt", 32'(wrc[2]), 32'd0);
    check("t6_oob1", 32'(oob[1]), 32'd0);
    check("t6_rdcnt1", 32'(rdc[1]), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    valid[2] = 1'b0;
    xfer(2, 32'h40, 32'h0, 4'h0, 32'h11111111, "t6_rd");
    check("t6_rdcnt2", 32'(rdc[2]), 32'd1);
    check("t6_oob2", 32'(oob[2]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
